// File: rtl/map_sprite_gen.sv
// map_sprite_gen: tiled course minimap with ball overlay and aim dots.
// Fixed 3-cycle pixel latency from hcount_in/vcount_in to RGB.
// Build option: define AIM_FADE_EN to darken the blue level of successive aim dots.

// Read-first single-port tile RAM with output register (2-cycle read latency).
module map_tile_ram #(
  parameter int DEPTH  = 14400,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        din,
  output logic [3:0]        dout
);
  logic [3:0] ram [0:DEPTH-1];
  logic [3:0] q_p0;

  // array read then output register; write port keeps the BRAM template shape
  always_ff @(posedge clk) begin
    if (we) ram[addr] <= din;
    q_p0 <= ram[addr];
    dout <= q_p0;
  end
endmodule

module map_sprite_gen #(
  parameter int MAP_W         = 160,
  parameter int MAP_H         = 90,
  parameter int TILE_LOG2     = 3,
  parameter int N_DOTS        = 3,
  parameter int DOT_SPACING   = 30,
  parameter int DOT_FADE_STEP = 48
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        frame_start_in,
  input  logic [15:0] ballx,
  input  logic [15:0] bally,
  input  logic [15:0] cos_abs,
  input  logic [15:0] sin_abs,
  input  logic        cos_sign,
  input  logic        sin_sign,
  input  logic        grass_color,
  output logic        frame_done_out,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out
);
  localparam int T      = 1 << TILE_LOG2;
  localparam int DEPTH  = MAP_W * MAP_H;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = (N_DOTS > 1) ? $clog2(N_DOTS) : 1;
  localparam logic signed [12:0] BOFF  = 13'(T / 2 - 1);
  localparam logic signed [12:0] BEDGE = 13'(T);
  localparam logic signed [17:0] XMAX  = 18'(MAP_W * T - 1);
  localparam logic signed [17:0] YMAX  = 18'(MAP_H * T - 1);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(N_DOTS - 1);
  localparam logic [23:0] WALL = 24'h8B4F39, GRASS_A = 24'h7CFC00, GRASS_B = 24'h73DE0B;
  localparam logic [23:0] SAND_A = 24'h9C972C, SAND_B = 24'hB0AA28;

  typedef enum logic [1:0] {IDLE, LATCH, CALC, COMMIT} state_t;

  function automatic logic mask_hit(input logic [TILE_LOG2-1:0] lx, input logic [TILE_LOG2-1:0] ly);
    int x, y, dx, dy;
    x  = int'(lx);
    y  = int'(ly);
    dx = (x < T - 1 - x) ? x : T - 1 - x;
    dy = (y < T - 1 - y) ? y : T - 1 - y;
    return (dx + dy) >= T / 4;
  endfunction

  function automatic logic [23:0] tile_rgb(input logic [3:0] code, input logic [TILE_LOG2-1:0] lx,
                                           input logic [TILE_LOG2-1:0] ly, input logic alt);
    int x, y;
    logic show;
    logic [23:0] base;
    x    = int'(lx);
    y    = int'(ly);
    base = code[0] ? (alt ? SAND_A : SAND_B) : (alt ? GRASS_A : GRASS_B);
    case (code)
      4'd4, 4'd5:   show = (T - 1 - x) >= y;
      4'd6, 4'd7:   show = (x + 1) < y;
      4'd8, 4'd9:   show = (T - 2 - x) < y;
      4'd10, 4'd11: show = (x + 1) > y;
      default:      show = 1'b1;
    endcase
    if (code == 4'd0)       return mask_hit(lx, ly) ? 24'h000000 : GRASS_A;
    else if (code == 4'd1)  return WALL;
    else if (code >= 4'd12) return 24'h000000;
    else                    return show ? base : WALL;
  endfunction

  function automatic logic [7:0] dot_level(input int idx);
    int lvl;
    lvl = 255 - idx * DOT_FADE_STEP;
    if (lvl < 64) lvl = 64;
    return 8'(lvl);
  endfunction

  logic unused_bits;
  assign unused_bits = ^{ballx[4:0], bally[15], bally[4:0]};

  // ---- stage 0: tile address and ball-box test from the raw counters
  logic [20:0]        addr_full;
  logic [ADDR_W-1:0]  addr;
  logic signed [12:0] blx, bly;
  logic               ball_in;
  logic [3:0]         tile_code;

  // tile address, clamped into the RAM for counters past the map edge
  always_comb begin
    addr_full = 21'(hcount_in >> TILE_LOG2) + 21'(vcount_in >> TILE_LOG2) * 21'(MAP_W);
    addr      = (addr_full < 21'(DEPTH)) ? addr_full[ADDR_W-1:0] : '0;
    blx       = $signed({2'b00, hcount_in}) - $signed({2'b00, ballx[15:5]}) + BOFF;
    bly       = $signed({3'b000, vcount_in}) - $signed({3'b000, bally[14:5]}) + BOFF;
    ball_in   = !blx[12] && (blx < BEDGE) && !bly[12] && (bly < BEDGE) &&
                mask_hit(blx[TILE_LOG2-1:0], bly[TILE_LOG2-1:0]);
  end

  map_tile_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) tile_ram (
    .clk(pixel_clk_in), .we(1'b0), .addr(addr), .din(4'd0), .dout(tile_code)
  );

  // ---- stages 1-2: delay counters and ball bit alongside the RAM read
  logic [10:0] h_p0, h_p1;
  logic [9:0]  v_p0, v_p1;
  logic        ball_p0, ball_p1;

  // align pixel coordinates with the tile code coming out of the RAM
  always_ff @(posedge pixel_clk_in) begin
    h_p0    <= hcount_in;
    v_p0    <= vcount_in;
    ball_p0 <= ball_in;
    h_p1    <= h_p0;
    v_p1    <= v_p0;
    ball_p1 <= ball_p0;
  end

  // ---- aim-dot FSM and shadow/display dot sets
  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [10:0]        bx_lat;
  logic [9:0]         by_lat;
  logic               cos_dir, sin_dir;
  logic [23:0]        step_x, step_y, acc_x, acc_y, acc_x_nx, acc_y_nx;
  logic signed [17:0] calc_x, calc_y;
  logic               calc_vld;
  logic signed [11:0] dot_x_sh [N_DOTS];
  logic signed [11:0] dot_y_sh [N_DOTS];
  logic signed [11:0] dot_x_dp [N_DOTS];
  logic signed [11:0] dot_y_dp [N_DOTS];
  logic [N_DOTS-1:0]  vld_sh, vld_dp;

  // FSM state register
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nx;
  end

  // next state: a frame start anywhere restarts at LATCH (COMMIT still finishes)
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (frame_start_in) state_nx = LATCH;
      LATCH:   state_nx = frame_start_in ? LATCH : CALC;
      CALC:    if (frame_start_in) state_nx = LATCH;
               else if (cnt == LAST) state_nx = COMMIT;
      COMMIT:  state_nx = frame_start_in ? LATCH : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // next accumulator value and the dot position it produces
  always_comb begin
    acc_x_nx = acc_x + step_x;
    acc_y_nx = acc_y + step_y;
    calc_x   = cos_dir ? $signed({7'd0, bx_lat}) + $signed({2'd0, acc_x_nx[23:8]})
                       : $signed({7'd0, bx_lat}) - $signed({2'd0, acc_x_nx[23:8]});
    calc_y   = sin_dir ? $signed({8'd0, by_lat}) - $signed({2'd0, acc_y_nx[23:8]})
                       : $signed({8'd0, by_lat}) + $signed({2'd0, acc_y_nx[23:8]});
    calc_vld = !calc_x[17] && (calc_x <= XMAX) && !calc_y[17] && (calc_y <= YMAX);
  end

  // dot datapath: latch inputs, accumulate one dot per cycle, copy on commit
  always_ff @(posedge pixel_clk_in) begin
    case (state)
      LATCH: begin
        bx_lat  <= ballx[15:5];
        by_lat  <= bally[14:5];
        cos_dir <= cos_sign;
        sin_dir <= sin_sign;
        step_x  <= 24'(DOT_SPACING * cos_abs);
        step_y  <= 24'(DOT_SPACING * sin_abs);
        acc_x   <= '0;
        acc_y   <= '0;
        cnt     <= '0;
      end
      CALC: begin
        acc_x         <= acc_x_nx;
        acc_y         <= acc_y_nx;
        dot_x_sh[cnt] <= calc_x[11:0];
        dot_y_sh[cnt] <= calc_y[11:0];
        cnt           <= cnt + 1'b1;
      end
      COMMIT: begin
        dot_x_dp <= dot_x_sh;
        dot_y_dp <= dot_y_sh;
      end
      default: ;
    endcase
  end

  // dot valid bits and commit pulse
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      vld_sh         <= '0;
      vld_dp         <= '0;
      frame_done_out <= 1'b0;
    end else begin
      frame_done_out <= (state == COMMIT);
      if (state == CALC)   vld_sh[cnt] <= calc_vld;
      if (state == COMMIT) vld_dp      <= vld_sh;
    end
  end

  // ---- stage 3: priority colour select into the output register
  logic       dot_hit;
  logic [7:0] dot_blue;
  logic [23:0] rgb;

  // lowest-numbered matching dot wins
  always_comb begin
    dot_hit  = 1'b0;
    dot_blue = 8'h00;
    for (int k = N_DOTS - 1; k >= 0; k--) begin
      if (vld_dp[k] && ($unsigned(dot_x_dp[k]) == {1'b0, h_p1}) &&
          ($unsigned(dot_y_dp[k]) == {2'b00, v_p1})) begin
        dot_hit = 1'b1;
`ifdef AIM_FADE_EN
        dot_blue = dot_level(k);
`else
        dot_blue = dot_level(0);
`endif
      end
    end
  end

  // registered RGB: dot > ball > tile
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in)       rgb <= 24'h000000;
    else if (dot_hit) rgb <= {16'h0000, dot_blue};
    else if (ball_p1) rgb <= 24'hFFFFFF;
    else              rgb <= tile_rgb(tile_code, h_p1[TILE_LOG2-1:0], v_p1[TILE_LOG2-1:0], grass_color);
  end

  assign red_out   = rgb[23:16];
  assign green_out = rgb[15:8];
  assign blue_out  = rgb[7:0];
endmodule

// File: tb/tb_map_sprite_gen.sv
// Self-checking bench for map_sprite_gen: randomized frames and pixels against a behavioural model.
module tb_map_sprite_gen;
  localparam int MAP_W = 160, MAP_H = 90, TL = 3, T = 8, N = 3, SP = 30, FADE = 48;
  localparam int PW = MAP_W * T, PH = MAP_H * T;

  logic clk = 1'b0, rst = 1'b1, frame_start = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic [15:0] ballx = '0, bally = '0, cos_abs = '0, sin_abs = '0;
  logic cos_sign = 1'b0, sin_sign = 1'b0, grass = 1'b0;
  logic frame_done;
  logic [7:0] red, green, blue;

  always #5 clk = ~clk;

  map_sprite_gen #(.MAP_W(MAP_W), .MAP_H(MAP_H), .TILE_LOG2(TL), .N_DOTS(N),
                   .DOT_SPACING(SP), .DOT_FADE_STEP(FADE)) dut (
    .pixel_clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
    .frame_start_in(frame_start), .ballx(ballx), .bally(bally), .cos_abs(cos_abs),
    .sin_abs(sin_abs), .cos_sign(cos_sign), .sin_sign(sin_sign), .grass_color(grass),
    .frame_done_out(frame_done), .red_out(red), .green_out(green), .blue_out(blue)
  );

  int n_tests = 0, n_fail = 0;
  int tmap [MAP_W*MAP_H];
  int m_dx [N], m_dy [N];
  bit m_vld [N];
  int qh [$], qv [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int mask_m(int lx, int ly);
    int ex, ey;
    ex = (lx < T - 1 - lx) ? lx : T - 1 - lx;
    ey = (ly < T - 1 - ly) ? ly : T - 1 - ly;
    return (ex + ey >= T / 4) ? 1 : 0;
  endfunction

  function automatic int tile_col(int code, int lx, int ly, bit alt);
    int base;
    bit show;
    if (code == 0) return mask_m(lx, ly) ? 0 : 'h7CFC00;
    if (code == 1) return 'h8B4F39;
    if (code >= 12) return 0;
    if (code % 2 == 1) base = alt ? 'h9C972C : 'hB0AA28;
    else               base = alt ? 'h7CFC00 : 'h73DE0B;
    show = 1;
    if (code == 4 || code == 5)   show = (T - 1 - lx >= ly);
    if (code == 6 || code == 7)   show = (lx + 1 < ly);
    if (code == 8 || code == 9)   show = (T - 2 - lx < ly);
    if (code == 10 || code == 11) show = (lx + 1 > ly);
    return show ? base : 'h8B4F39;
  endfunction

  function automatic int blue_m(int k);
`ifdef AIM_FADE_EN
    int b;
    b = 255 - k * FADE;
    return (b < 64) ? 64 : b;
`else
    return 255 + 0 * k;
`endif
  endfunction

  function automatic int model_pix(int h, int v);
    int bx, by, idx;
    bx = int'(ballx[15:5]);
    by = int'(bally[14:5]);
    for (int k = 0; k < N; k++)
      if (m_vld[k] && h == m_dx[k] && v == m_dy[k]) return blue_m(k);
    if (h >= bx - (T/2 - 1) && h <= bx + T/2 && v >= by - (T/2 - 1) && v <= by + T/2 &&
        mask_m(h - bx + T/2 - 1, v - by + T/2 - 1) == 1) return 'hFFFFFF;
    idx = h / T + (v / T) * MAP_W;
    if (idx >= MAP_W * MAP_H) idx = 0;
    return tile_col(tmap[idx], h % T, v % T, grass);
  endfunction

  task automatic model_commit();
    int bx, by, ox, oy;
    bx = int'(ballx[15:5]);
    by = int'(bally[14:5]);
    for (int k = 0; k < N; k++) begin
      ox = ((k + 1) * SP * int'(cos_abs)) >> 8;
      oy = ((k + 1) * SP * int'(sin_abs)) >> 8;
      m_dx[k]  = cos_sign ? bx + ox : bx - ox;
      m_dy[k]  = sin_sign ? by - oy : by + oy;
      m_vld[k] = m_dx[k] >= 0 && m_dx[k] < PW && m_dy[k] >= 0 && m_dy[k] < PH;
    end
  endtask

  task automatic set_tile(input int tx, input int ty, input int code);
    tmap[tx + ty * MAP_W] = code;
    dut.tile_ram.ram[tx + ty * MAP_W] <= 4'(code);
  endtask

  task automatic set_ball(input int bx, input int by, input int c, input int s, input bit cs, input bit ss);
    @(negedge clk);
    ballx    = {bx[10:0], 5'($urandom_range(31, 0))};
    bally    = {1'b0, by[9:0], 5'($urandom_range(31, 0))};
    cos_abs  = 16'(c);
    sin_abs  = 16'(s);
    cos_sign = cs;
    sin_sign = ss;
  endtask

  task automatic push_pt(input int h, input int v);
    if (h >= 0 && h < PW && v >= 0 && v < PH) begin
      qh.push_back(h);
      qv.push_back(v);
    end
  endtask

  // Drive the queued pixels back to back; each output is due three cycles after its input.
  task automatic run_pts(input string tag);
    int e [$];
    int n;
    n = qh.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i < n) begin
        hcount = 11'(qh[i]);
        vcount = 10'(qv[i]);
        e.push_back(model_pix(qh[i], qv[i]));
      end
      @(posedge clk); #1;
      if (i >= 2) check(tag, {8'h00, red, green, blue}, e[i-2]);
    end
    qh.delete();
    qv.delete();
  endtask

  // Pulse frame_start at cycle 0 (and again at re_at), optional reset at rst_at; watch frame_done.
  task automatic pulse_watch(input string tag, input int re_at, input int rst_at,
                             input int exp_lat, input int exp_cnt);
    int lat, hi;
    lat = 0;
    hi  = 0;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      frame_start = (c == 0 || c == re_at);
      rst         = (c == rst_at);
      @(posedge clk); #1;
      if (frame_done) begin
        hi++;
        if (lat == 0) lat = c;
      end
      if (c == rst_at) check({tag, "_rst_rgb"}, {red, green, blue}, 0);
    end
    @(negedge clk);
    frame_start = 1'b0;
    rst         = 1'b0;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_cnt"}, hi, exp_cnt);
    if (rst_at >= 0) for (int k = 0; k < N; k++) m_vld[k] = 0;
    else model_commit();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ox [N], oy [N];
    for (int k = 0; k < N; k++) m_vld[k] = 0;
    for (int i = 0; i < MAP_W * MAP_H; i++) begin
      tmap[i] = $urandom_range(15, 0);
      dut.tile_ram.ram[i] <= 4'(tmap[i]);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("reset_rgb", {red, green, blue}, 0);
      check("reset_done", frame_done, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_done", frame_done, 0);
    end

    // horizontal dots from (100,50)
    set_ball(100, 50, 256, 0, 1'b1, 1'b0);
    grass = 1'b1;
    pulse_watch("dots_h", -1, -1, N + 2, 1);
    for (int k = 0; k < N; k++) begin
      push_pt(m_dx[k], m_dy[k]);
      push_pt(m_dx[k] + 1, m_dy[k]);
      push_pt(m_dx[k], m_dy[k] + 1);
    end
    push_pt(100, 50); push_pt(97, 47); push_pt(98, 48);
    run_pts("dots_h_pix");

    // wall tile between grass and black tiles, swept along one row
    set_tile(1, 3, 2); set_tile(2, 3, 1); set_tile(3, 3, 12);
    for (int h = 8; h < 32; h++) push_pt(h, 24);
    run_pts("wall_sweep");

    // diagonal code 4, lx = 5, both palettes
    set_tile(5, 5, 4);
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      grass = g[0];
      for (int ly = 0; ly < T; ly++) push_pt(45, 40 + ly);
      push_pt(44, 41); push_pt(46, 42);
      run_pts("diag4");
    end

    // ball near origin pointing left: all dots off-map
    set_ball(3, 3, 256, 0, 1'b0, 1'b0);
    pulse_watch("dots_left", -1, -1, N + 2, 1);
    push_pt(0, 0); push_pt(0, 1); push_pt(1, 1); push_pt(3, 3);
    push_pt(7, 7); push_pt(6, 6); push_pt(8, 3); push_pt(3, 0);
    run_pts("ball_box");

    // ball near right edge pointing right: dots beyond the last column
    set_ball(1270, 50, 256, 0, 1'b1, 1'b0);
    pulse_watch("dots_right", -1, -1, N + 2, 1);
    push_pt(1300, 50); push_pt(1330, 50); push_pt(1270, 50);
    run_pts("dots_right_pix");

    // restart in CALC, frame start during COMMIT
    set_ball(400, 300, 200, 100, 1'b1, 1'b1);
    pulse_watch("restart", 2, -1, N + 4, 1);
    pulse_watch("commit_fs", N + 2, -1, N + 2, 2);
    for (int k = 0; k < N; k++) begin
      ox[k] = m_dx[k];
      oy[k] = m_dy[k];
      push_pt(m_dx[k], m_dy[k]);
    end
    run_pts("restart_pix");

    // restart then reset mid-calculation: no commit, dots cleared
    pulse_watch("abort", 2, 5, 0, 0);
    for (int k = 0; k < N; k++) push_pt(ox[k], oy[k]);
    run_pts("abort_pix");

    // randomized frames
    for (int r = 0; r < 10; r++) begin
      int bx, by;
      bx = $urandom_range(PW - 1, 0);
      by = $urandom_range(PH - 1, 0);
      set_ball(bx, by, $urandom_range(256, 0), $urandom_range(256, 0),
               1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      @(negedge clk);
      grass = 1'($urandom_range(1, 0));
      pulse_watch("rand_frame", -1, -1, N + 2, 1);
      for (int k = 0; k < N; k++) begin
        push_pt(m_dx[k], m_dy[k]);
        push_pt(m_dx[k] - 1, m_dy[k]);
      end
      for (int j = 0; j < 6; j++)
        push_pt(bx - 3 + $urandom_range(T - 1, 0), by - 3 + $urandom_range(T - 1, 0));
      for (int j = 0; j < 8; j++)
        push_pt($urandom_range(PW - 1, 0), $urandom_range(PH - 1, 0));
      run_pts("rand_pix");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
